// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC receive path: FSM states, the DTC sign
// convention and the saturation limits of a WIDTH-bit two's-complement code.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } tdc_state_e;

  // Same polarity the DTC driver uses for its sign flag.
  localparam logic SIGN_POS = 1'b1;
  localparam logic SIGN_NEG = 1'b0;

  // Largest positive code, 2^(width-1)-1.
  function automatic int unsigned pos_limit(input int unsigned width);
    return (32'd1 << (width - 32'd1)) - 32'd1;
  endfunction

  // Largest negative magnitude, 2^(width-1).
  function automatic int unsigned neg_limit(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

endpackage

// File: rtl/tdc_edge_det.sv
// Rising-edge detector for one pulse input. With TDC_SIGNED_SYNC_EN defined
// the input first crosses a 2-flop synchronizer (adds 2 cycles of delay).
module tdc_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic edge_o
);

  logic samp;
  logic prev_q;

`ifdef TDC_SIGNED_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], in_i};
    end
  end

  assign samp = sync_q[1];
`else
  assign samp = in_i;
`endif

  // History updates every cycle so a level already high at arm time is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= samp;
    end
  end

  assign edge_o = samp & ~prev_q;

endmodule

// File: rtl/tdc_signed.sv
// Signed time-to-digital converter: measures ref->dtc edge spacing in clk
// cycles and returns a saturated two's-complement code. Option: TDC_SIGNED_SYNC_EN.
module tdc_signed
  import tdc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             ref_in,
  input  logic             dtc_in,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_sign,
  output logic             dout_valid,
  output logic             ovf,
  output tdc_state_e       dbg_state
);

  // Handshake: arm is a one-cycle request honoured only in IDLE (busy=0 and not
  // finishing); dout_valid is a one-cycle strobe with no back-pressure, and
  // dout/dout_sign/ovf hold their values until the next strobe or arm.

  localparam logic [WIDTH-1:0] POS_MAX = WIDTH'(pos_limit(unsigned'(WIDTH)));
  localparam logic [WIDTH-1:0] NEG_MAG = WIDTH'(neg_limit(unsigned'(WIDTH)));
  localparam logic [WIDTH-1:0] TMAX    = WIDTH'(TIMEOUT);

  logic ref_edge;
  logic dtc_edge;

  tdc_edge_det u_ref_det (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .in_i   (ref_in),
    .edge_o (ref_edge)
  );

  tdc_edge_det u_dtc_det (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .in_i   (dtc_in),
    .edge_o (dtc_edge)
  );

  tdc_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             msign_q, msign_d;
  logic             tout_q, tout_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dsign_q, dsign_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             opp_edge;
  logic [WIDTH-1:0] conv;
  logic             clamp;

  // Magnitude plus sign to saturated code; -0 cannot occur because a zero
  // magnitude is only produced together with SIGN_POS.
  always_comb begin
    conv  = '0;
    clamp = 1'b0;
    if (msign_q == SIGN_POS) begin
      if (mag_q > POS_MAX) begin
        conv  = POS_MAX;
        clamp = 1'b1;
      end else begin
        conv = mag_q;
      end
    end else begin
      if (mag_q > NEG_MAG) begin
        conv  = NEG_MAG;
        clamp = 1'b1;
      end else begin
        conv = ~mag_q + 1'b1;
      end
    end
  end

  assign opp_edge = (msign_q == SIGN_POS) ? dtc_edge : ref_edge;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    msign_d = msign_q;
    tout_d  = tout_q;
    dout_d  = dout_q;
    dsign_d = dsign_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (ref_edge && dtc_edge) begin
          mag_d   = '0;
          msign_d = SIGN_POS;
          tout_d  = 1'b0;
          state_d = DONE;
        end else if (ref_edge) begin
          msign_d = SIGN_POS;
          cnt_d   = WIDTH'(1);
          state_d = COUNT;
        end else if (dtc_edge) begin
          msign_d = SIGN_NEG;
          cnt_d   = WIDTH'(1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (opp_edge) begin
          mag_d   = cnt_q;
          tout_d  = 1'b0;
          state_d = DONE;
        end else if (cnt_q == TMAX) begin
          mag_d   = TMAX;
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        dout_d  = conv;
        dsign_d = msign_q;
        ovf_d   = tout_q | clamp;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      msign_q <= SIGN_POS;
      tout_q  <= 1'b0;
      dout_q  <= '0;
      dsign_q <= SIGN_POS;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      msign_q <= msign_d;
      tout_q  <= tout_d;
      dout_q  <= dout_d;
      dsign_q <= dsign_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy       = (state_q == ARMED) || (state_q == COUNT);
  assign dout       = dout_q;
  assign dout_sign  = dsign_q;
  assign dout_valid = valid_q;
  assign ovf        = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tdc_signed.sv
// Self-checking bench for tdc_signed: directed vector table, reset corner
// sequences and randomized measurements against an arithmetic reference model.
module tb_tdc_signed;
  import tdc_pkg::*;

  localparam int W       = 8;
  localparam int TIMEOUT = 255;
`ifdef TDC_SIGNED_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         arm = 1'b0;
  logic         ref_in = 1'b0;
  logic         dtc_in = 1'b0;
  logic         busy;
  logic [W-1:0] dout;
  logic         dout_sign;
  logic         dout_valid;
  logic         ovf;
  tdc_state_e   dbg_state;

  tdc_signed #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .ref_in     (ref_in),
    .dtc_in     (dtc_in),
    .busy       (busy),
    .dout       (dout),
    .dout_sign  (dout_sign),
    .dout_valid (dout_valid),
    .ovf        (ovf),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: edge times relative to the arm cycle (-1 = no edge).
  // Returns {ovf, sign, dout}.
  function automatic logic [W+1:0] model(input int dr, input int dd);
    int m;
    int gap;
    bit pos;
    bit ov;
    logic [W-1:0] o;
    ov = 1'b0;
    if (dr >= 0 && dd >= 0 && dr == dd) begin
      m   = 0;
      pos = 1'b1;
    end else begin
      pos = (dr >= 0) && (dd < 0 || dr < dd);
      gap = (dr > dd) ? dr - dd : dd - dr;
      if (dr >= 0 && dd >= 0 && gap <= TIMEOUT) begin
        m = gap;
      end else begin
        m  = TIMEOUT;
        ov = 1'b1;
      end
    end
    if (pos && m > (2 ** (W - 1)) - 1) begin
      m  = (2 ** (W - 1)) - 1;
      ov = 1'b1;
    end else if (!pos && m > 2 ** (W - 1)) begin
      m  = 2 ** (W - 1);
      ov = 1'b1;
    end
    o = pos ? W'(m) : W'(-m);
    return {ov, pos, o};
  endfunction

  // ---------------- driver ----------------
  // Pulses are one cycle wide; c is the posedge index counted from the arm edge.
  // extra = a second pulse on the first source, arm_x = stray arm (>0 absolute,
  // -1 = on the DONE->IDLE cycle, 0 = none).
  task automatic run_meas(input string nm, input int dr, input int dd, input int extra,
                          input int arm_x, input logic [W-1:0] e_dout, input logic e_sign,
                          input logic e_ovf);
    int f, gap, close, lim, vcnt, vcyc;
    bit busy_bad, ref_first;
    logic [W+1:0] exp_w, got_w;
    ref_first = (dr >= 0) && (dd < 0 || dr <= dd);
    f = ref_first ? dr : dd;
    if (dr >= 0 && dd >= 0) gap = (dr > dd) ? dr - dd : dd - dr;
    else gap = TIMEOUT;
    if (gap > TIMEOUT) gap = TIMEOUT;
    close = f + gap + LAT;
    lim = close + 4;
    exp_q.push_back({e_ovf, e_sign, e_dout});
    vcnt = 0;
    vcyc = -1;
    busy_bad = 1'b0;
    got_w = '0;
    for (int c = 0; c <= lim; c++) begin
      arm    = (c == 0) || (arm_x > 0 && c == arm_x) || (arm_x < 0 && c == close + 1);
      ref_in = (c == dr) || (ref_first && c == extra);
      dtc_in = (c == dd) || (!ref_first && c == extra);
      @(posedge clk); #1;
      if (dout_valid === 1'b1) begin
        vcnt++;
        vcyc = c;
        got_w = {ovf, dout_sign, dout};
      end
      if (busy !== (c < close)) busy_bad = 1'b1;
    end
    arm = 1'b0;
    ref_in = 1'b0;
    dtc_in = 1'b0;
    exp_w = exp_q.pop_front();
    chk({nm, "_valid_count"}, vcnt, 1);
    chk({nm, "_latency"}, vcyc, close + 1);
    chk({nm, "_result"}, got_w, exp_w);
    chk({nm, "_busy"}, busy_bad, 0);
    chk({nm, "_held"}, {ovf, dout_sign, dout}, exp_w);
  endtask

  typedef struct {
    int           dr;
    int           dd;
    int           extra;
    int           arm_x;
    logic [W-1:0] e_dout;
    logic         e_sign;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int vseen;
    bit bbad;
    int dr, dd, base, off, f, open, extra, arm_x, mode;
    logic [W+1:0] m;

    tbl[0]  = '{3,   8,   -1, 5,  8'h05, 1'b1, 1'b0};
    tbl[1]  = '{5,   2,   -1, -1, 8'hFD, 1'b0, 1'b0};
    tbl[2]  = '{4,   4,   -1, 0,  8'h00, 1'b1, 1'b0};
    tbl[3]  = '{1,   201, 50, 0,  8'h7F, 1'b1, 1'b1};
    tbl[4]  = '{129, 1,   -1, 0,  8'h80, 1'b0, 1'b0};
    tbl[5]  = '{2,   -1,  10, 0,  8'h7F, 1'b1, 1'b1};
    tbl[6]  = '{130, 1,   -1, 0,  8'h80, 1'b0, 1'b1};
    tbl[7]  = '{1,   128, -1, 0,  8'h7F, 1'b1, 1'b0};
    tbl[8]  = '{-1,  1,   -1, 0,  8'h80, 1'b0, 1'b1};
    tbl[9]  = '{2,   3,   -1, -1, 8'h01, 1'b1, 1'b0};
    tbl[10] = '{5,   4,   -1, 0,  8'hFF, 1'b0, 1'b0};
    tbl[11] = '{1,   256, -1, 0,  8'h7F, 1'b1, 1'b1};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_sign", dout_sign, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_meas($sformatf("vec%0d", i), tbl[i].dr, tbl[i].dd, tbl[i].extra, tbl[i].arm_x,
               tbl[i].e_dout, tbl[i].e_sign, tbl[i].e_ovf);
    end

    // Reset in the middle of a count (previous result left ovf=1, dout=7F).
    for (int c = 0; c < 12; c++) begin
      arm = (c == 0);
      ref_in = (c == 2);
      dtc_in = 1'b0;
      @(posedge clk); #1;
    end
    chk("midrst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_sign", dout_sign, 1);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_valid", dout_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vseen = 0;
    bbad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      dtc_in = (c == 3);
      @(posedge clk); #1;
      if (dout_valid === 1'b1) vseen++;
      if (busy !== 1'b0) bbad = 1'b1;
    end
    dtc_in = 1'b0;
    chk("midrst_no_valid", vseen, 0);
    chk("midrst_stays_idle", bbad, 0);
    run_meas("post_reset", 2, 9, -1, 4, 8'h07, 1'b1, 1'b0);

    // Randomized measurements.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 9);
      base = $urandom_range(1, 6);
      case ($urandom_range(0, 3))
        0, 1: off = $urandom_range(1, 20);
        2: off = $urandom_range(120, 140);
        default: off = $urandom_range(200, 300);
      endcase
      if (mode <= 3) begin
        dr = base; dd = base + off;
      end else if (mode <= 7) begin
        dd = base; dr = base + off;
      end else if (mode == 8) begin
        dr = base; dd = base;
      end else if ($urandom_range(0, 1) == 1) begin
        dr = base; dd = -1;
      end else begin
        dr = -1; dd = base;
      end
      f = (dr >= 0 && (dd < 0 || dr <= dd)) ? dr : dd;
      if (dr >= 0 && dd >= 0) open = ((dr > dd) ? dr - dd : dd - dr) - 1;
      else open = 20;
      if (open > 20) open = 20;
      extra = -1;
      if (open >= 2 && $urandom_range(0, 1) == 1) extra = f + $urandom_range(2, open);
      arm_x = 0;
      case ($urandom_range(0, 3))
        0: arm_x = -1;
        1: if (dr != dd) arm_x = f + 1;
        default: arm_x = 0;
      endcase
      m = model(dr, dd);
      run_meas($sformatf("rnd%0d", i), dr, dd, extra, arm_x, m[W-1:0], m[W], m[W+1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog: every wait above is cycle-bounded, this only guards the bench itself.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/tdc_signed.md
Name: tdc_signed

Overview:
- Time-to-digital measurement block. It is the receive end of the DTC path: the DTC driver turns a signed code into a sign flag plus a magnitude delay.
- This block measures the interval between a reference edge and the DTC output edge in clk cycles. It rebuilds a saturated two's-complement code from that interval.
- It sits after the DTC in loopback and calibration paths, and feeds the signed result back to digital logic.

Parameters:
- WIDTH, 8: bit width of the signed result dout.
- TIMEOUT, 255: maximum number of counted cycles before a forced finish. Legal range is 1..2^WIDTH-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle request to start one measurement. Accepted in IDLE only.
- ref_in  in  1  reference pulse, level input.
- dtc_in  in  1  DTC output pulse, level input.
- busy  out  1  high while in ARMED or COUNT.
- dout  out  WIDTH  signed result in two's complement. Held until the next result.
- dout_sign  out  1  1 = positive (ref edge first), 0 = negative (dtc edge first).
- dout_valid  out  1  one-cycle pulse when dout and dout_sign update.
- ovf  out  1  set with dout_valid when the result saturated or timed out; cleared on the next arm.

Behaviour:
- Reset values: all outputs 0 except dout_sign=1. Counter=0, state=IDLE, edge-history flops=0.
- Edge detect: a rising edge is registered in the cycle where the input samples 1 and its previous sample was 0. The previous-sample flops update in every state.
- States: IDLE, ARMED, COUNT, DONE.
- IDLE, arm=1: go to ARMED, clear ovf, clear counter. arm in any other state is ignored.
- ARMED:
  - Both edges in the same cycle: result 0, sign=1, go to DONE.
  - ref edge only: sign=1, counter=1, go to COUNT.
  - dtc edge only: sign=0, counter=1, go to COUNT.
- COUNT:
  - The counter increments once per cycle with no edge from the opposite source.
  - A second edge from the first source is ignored.
  - Opposite edge: latch counter as magnitude, go to DONE.
  - Counter reaches TIMEOUT: latch TIMEOUT, set ovf, go to DONE.
  - Result: an opposite edge N cycles after the first edge gives magnitude N.
- DONE: load the outputs, pulse dout_valid for one cycle, return to IDLE. Latency is 1 cycle from the closing edge detection to dout_valid.
- Conversion from magnitude m (unsigned, width WIDTH):
  - sign=1: dout = min(m, 2^(WIDTH-1)-1).
  - sign=0: dout = -min(m, 2^(WIDTH-1)).
  - ovf is also set when clamping occurred.
  - +0 is always reported with sign=1; -0 is never produced.
- An arm pulse in the same cycle as the DONE->IDLE transition is ignored. arm must arrive while in IDLE.
- Reset mid-measurement aborts immediately: no dout_valid, outputs return to reset values.

Optional Feature:
- Macro TDC_SIGNED_SYNC_EN.
- Defined: ref_in and dtc_in each pass through a 2-flop synchronizer ahead of edge detection. This adds 2 cycles to every edge. Measured differences and the arm-to-edge relation are otherwise unchanged.
- Undefined: inputs are taken as synchronous to clk and go straight to edge detection.

Decomposition:
- Shared package tdc_pkg holds:
  - the state enum {IDLE, ARMED, COUNT, DONE};
  - constants SIGN_POS=1'b1 and SIGN_NEG=1'b0, shared with the DTC sign convention;
  - the saturation limit function or constants derived from WIDTH.
- One sub-module, tdc_edge_det: optional synchronizer plus rising-edge detector, instantiated twice (ref, dtc).

Test Plan:
- arm; ref edge at cycle t, dtc edge at t+5 -> dout=8'h05, dout_sign=1, ovf=0, dout_valid at t+6.
- arm; dtc edge at t, ref edge at t+3 -> dout=8'hFD (-3), dout_sign=0, ovf=0.
- arm; ref and dtc edges in the same cycle -> dout=8'h00, dout_sign=1, ovf=0.
- arm; ref edge, dtc edge 200 cycles later -> dout=8'h7F, ovf=1. Negative case (dtc first) with a 128-cycle gap -> dout=8'h80, ovf=0.
- arm; ref edge only, no dtc edge -> after TIMEOUT=255 cycles, dout=8'h7F, ovf=1, dout_valid pulses once.
- rst_n low during COUNT -> busy=0, no dout_valid, dout=0, dout_sign=1. A later arm measures normally. arm during busy is ignored.
